dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single 64-bit-word data memory port.
- Requester 0 is the core load/store path; requester 1 is the debug/loader port, used by benches and the boot loader to preload or inspect memory without hierarchical pokes.
- Serialises accesses, converts byte addresses to word indices, checks alignment and returns one response per accepted request.

---
 rtl/dmem_arbiter.sv | 100 ++++++++++
 tb/tb_dmem_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter and sequencer for the single 64-bit data memory port.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   c_req_* / c_resp_*                  core load/store requester (priority port)
//   d_req_* / d_resp_*                  debug/loader requester
//   mem_en, mem_we, mem_addr, mem_wdata registered memory strobe, write enable, word index, write data
//   mem_rdata                           read data, valid the cycle after a load strobe
// Build option: DMEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed core priority.
module dmem_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int IDX_W  = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              c_req_valid,
   output logic              c_req_ready,
   input  logic              c_req_we,
   input  logic [ADDR_W-1:0] c_req_addr,
   input  logic [DATA_W-1:0] c_req_wdata,
   output logic              c_resp_valid,
   output logic [DATA_W-1:0] c_resp_rdata,
   output logic              c_resp_err,
   input  logic              d_req_valid,
   output logic              d_req_ready,
   input  logic              d_req_we,
   input  logic [ADDR_W-1:0] d_req_addr,
   input  logic [DATA_W-1:0] d_req_wdata,
   output logic              d_resp_valid,
   output logic [DATA_W-1:0] d_resp_rdata,
   output logic              d_resp_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [IDX_W-1:0]  mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;
   state_t state, state_next;
   logic gnt_c, gnt_d, hs, misal, owner, rsp_valid, rsp_err, unused_addr;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] rsp_rdata;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
   // last_grant: 0 = core, 1 = debug; starts at 1 so the core wins the first tie
   logic last_grant;
   assign gnt_c = c_req_valid & (~d_req_valid | last_grant);
   always_ff @(posedge clk)
      if (reset) last_grant <= 1'b1;
      else if (hs) last_grant <= gnt_d;
`else
   assign gnt_c = c_req_valid;
`endif
   assign gnt_d       = d_req_valid & ~gnt_c;
   assign c_req_ready = gnt_c & (state == IDLE);
   assign d_req_ready = gnt_d & (state == IDLE);
   assign hs          = c_req_ready | d_req_ready;
   assign sel_addr    = gnt_d ? d_req_addr : c_req_addr;
   assign misal       = |sel_addr[2:0];
   // address bits above the word index wrap modulo memory size
   assign unused_addr = ^sel_addr[ADDR_W-1:IDX_W+3];
   // response registers are shared; only the owner's port sees them
   assign c_resp_valid = rsp_valid & ~owner;
   assign d_resp_valid = rsp_valid & owner;
   assign c_resp_err   = c_resp_valid & rsp_err;
   assign d_resp_err   = d_resp_valid & rsp_err;
   assign c_resp_rdata = c_resp_valid ? rsp_rdata : '0;
   assign d_resp_rdata = d_resp_valid ? rsp_rdata : '0;
   always_ff @(posedge clk)
      if (reset) state <= IDLE;
      else state <= state_next;
   always_comb begin
      state_next = state;
      state_next = state == IDLE    ? (hs ? (misal ? RESP : ACCESS) : IDLE) :
                   state == ACCESS  ? (mem_we ? RESP : CAPTURE) :
                   state == CAPTURE ? RESP : IDLE;
   end
   always_ff @(posedge clk)
      if (reset) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         owner     <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         mem_en    <= hs & ~misal;
         rsp_valid <= (hs & misal) | (state == ACCESS & mem_we) | (state == CAPTURE);
         if (hs) begin
            owner     <= gnt_d;
            mem_we    <= gnt_d ? d_req_we : c_req_we;
            mem_addr  <= sel_addr[IDX_W+2:3];
            mem_wdata <= gnt_d ? d_req_wdata : c_req_wdata;
            rsp_err   <= misal;
            rsp_rdata <= '0;
         end
         if (state == CAPTURE) rsp_rdata <= mem_rdata;
      end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a memory model and a transaction-level reference.
module tb_dmem_arbiter;
   logic clk = 0, reset = 1;
   logic c_req_valid = 0, c_req_we = 0, d_req_valid = 0, d_req_we = 0;
   logic [63:0] c_req_addr = 0, c_req_wdata = 0, d_req_addr = 0, d_req_wdata = 0;
   logic c_req_ready, d_req_ready, c_resp_valid, d_resp_valid, c_resp_err, d_resp_err;
   logic [63:0] c_resp_rdata, d_resp_rdata, mem_wdata, mem_rdata;
   logic mem_en, mem_we;
   logic [9:0] mem_addr;
   logic [63:0] mem [1024];
   logic [63:0] ref_mem [1024];
   int n_cmp = 0, n_err = 0, cyc = 0, hs_cyc = 0, waited = 0;
   bit last_port = 1;

   dmem_arbiter dut (
      .clk(clk), .reset(reset),
      .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_we(c_req_we),
      .c_req_addr(c_req_addr), .c_req_wdata(c_req_wdata), .c_resp_valid(c_resp_valid),
      .c_resp_rdata(c_resp_rdata), .c_resp_err(c_resp_err),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
      .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_resp_valid(d_resp_valid),
      .d_resp_rdata(d_resp_rdata), .d_resp_err(d_resp_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk)
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else mem_rdata <= mem[mem_addr];
      end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, got, exp);
      end
   endtask

   // reference: one accepted request -> one response, from the address/latency rules
   task automatic model(input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                        output bit err, output logic [63:0] rdata, output int lat, output int idx);
      idx   = int'((addr / 8) % 1024);
      err   = (addr % 8) != 0;
      lat   = err ? 1 : (we ? 2 : 3);
      rdata = (!err && !we) ? ref_mem[idx] : 64'd0;
      if (!err && we) ref_mem[idx] = wdata;
   endtask

   task automatic do_req(input string name, input bit port, input bit we, input logic [63:0] addr,
                         input logic [63:0] wdata, input bit exp_err, input logic [63:0] exp_rdata,
                         input int exp_lat, input int exp_idx);
      int w, lat, ens;
      bit got, other;
      logic [63:0] rdata, en_wdata;
      logic err, en_we;
      logic [9:0] en_addr;
      got = 0; other = 0; ens = 0; rdata = 0; err = 0; en_we = 0; en_addr = 0; en_wdata = 0;
      @(negedge clk);
      if (port) begin d_req_valid = 1; d_req_we = we; d_req_addr = addr; d_req_wdata = wdata; end
      else begin c_req_valid = 1; c_req_we = we; c_req_addr = addr; c_req_wdata = wdata; end
      #1;
      w = 0;
      while (!(port ? d_req_ready : c_req_ready) && w < 20) begin @(negedge clk); w++; end
      if (w == 20) begin
         check({name, "_ready_timeout"}, 0, 1);
         c_req_valid = 0; d_req_valid = 0;
         return;
      end
      hs_cyc = cyc; waited = w; last_port = port;
      lat = 0;
      while (lat < 8 && !got) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin c_req_valid = 0; d_req_valid = 0; #1; end
         if (mem_en) begin ens++; en_addr = mem_addr; en_we = mem_we; en_wdata = mem_wdata; end
         if (port ? c_resp_valid : d_resp_valid) other = 1;
         if (port ? d_resp_valid : c_resp_valid) begin
            got = 1;
            rdata = port ? d_resp_rdata : c_resp_rdata;
            err = port ? d_resp_err : c_resp_err;
         end
      end
      check({name, "_resp"}, 64'(got), 1);
      check({name, "_lat"}, 64'(lat), 64'(exp_lat));
      check({name, "_rdata"}, rdata, exp_rdata);
      check({name, "_err"}, 64'(err), 64'(exp_err));
      check({name, "_other_resp"}, 64'(other), 0);
      check({name, "_strobes"}, 64'(ens), exp_err ? 0 : 1);
      if (ens == 1) begin
         check({name, "_mem_addr"}, 64'(en_addr), 64'(exp_idx));
         check({name, "_mem_we"}, 64'(en_we), 64'(we));
         if (we) check({name, "_mem_wdata"}, en_wdata, wdata);
      end
   endtask

   typedef struct {
      bit port; bit we; logic [63:0] addr; logic [63:0] wdata;
      bit err; logic [63:0] rdata; int lat; int idx;
   } vec_t;

   initial begin
      vec_t tv [11];
      bit m_err;
      logic [63:0] m_rd, a, v;
      int m_lat, m_idx, hs0, n_g, prev;
      bit exp_g, flag;
      bit grants [$];
      tv[0]  = '{1, 1, 64'h200, 64'hB, 0, 0, 2, 64};
      tv[1]  = '{0, 1, 64'h100, 64'h1234567890ABCDEF, 0, 0, 2, 32};
      tv[2]  = '{0, 0, 64'h100, 0, 0, 64'h1234567890ABCDEF, 3, 32};
      tv[3]  = '{0, 0, 64'h104, 0, 1, 0, 1, 32};
      tv[4]  = '{1, 0, 64'h200, 0, 0, 64'hB, 3, 64};
      tv[5]  = '{0, 1, 64'h2008, 64'h55, 0, 0, 2, 1};
      tv[6]  = '{1, 0, 64'h8, 0, 0, 64'h55, 3, 1};
      tv[7]  = '{0, 1, 64'hFFFF000000000010, 64'h77, 0, 0, 2, 2};
      tv[8]  = '{1, 0, 64'h10, 0, 0, 64'h77, 3, 2};
      tv[9]  = '{1, 1, 64'h201, 64'hDEAD, 1, 0, 1, 64};
      tv[10] = '{0, 0, 64'h200, 0, 0, 64'hB, 3, 64};
      for (int i = 0; i < 1024; i++) begin
         v = {$urandom(), $urandom()};
         mem[i] <= v;
         ref_mem[i] = v;
      end
      repeat (2) @(negedge clk);
      check("rst_mem_en", 64'(mem_en), 0);
      check("rst_mem_we", 64'(mem_we), 0);
      check("rst_mem_addr", 64'(mem_addr), 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_c_resp", {c_resp_valid, c_resp_err, c_resp_rdata[61:0]}, 0);
      check("rst_d_resp", {d_resp_valid, d_resp_err, d_resp_rdata[61:0]}, 0);
      reset = 0;

      for (int i = 0; i < 11; i++) begin
         model(tv[i].we, tv[i].addr, tv[i].wdata, m_err, m_rd, m_lat, m_idx);
         do_req($sformatf("vec%0d", i), tv[i].port, tv[i].we, tv[i].addr, tv[i].wdata,
                tv[i].err, tv[i].rdata, tv[i].lat, tv[i].idx);
      end

      // back-to-back core stores: handshakes 3 cycles apart
      prev = 0;
      for (int i = 0; i < 3; i++) begin
         a = 64'(i * 8);
         model(1, a, 64'(100 + i), m_err, m_rd, m_lat, m_idx);
         do_req($sformatf("b2b%0d", i), 0, 1, a, 64'(100 + i), 0, 0, 2, i);
         if (i > 0) check($sformatf("b2b%0d_gap", i), 64'(hs_cyc - prev), 3);
         prev = hs_cyc;
      end

      // both ports request continuously
      @(negedge clk);
      c_req_valid = 1; c_req_we = 0; c_req_addr = 64'h100;
      d_req_valid = 1; d_req_we = 0; d_req_addr = 64'h200;
      #1;
      hs0 = cyc;
      for (int i = 0; i < 24; i++) begin
         if (c_req_ready && d_req_ready) check("both_ready", 1, 0);
         if (c_req_ready) grants.push_back(0);
         if (d_req_ready) grants.push_back(1);
         @(negedge clk);
      end
      c_req_valid = 0; d_req_valid = 0;
      check("tie_grants", 64'(grants.size()), 6);
      n_g = grants.size();
      for (int i = 0; i < n_g; i++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
         exp_g = ~last_port;
`else
         exp_g = 0;
`endif
         check($sformatf("tie_grant%0d", i), 64'(grants[i]), 64'(exp_g));
         last_port = grants[i];
      end
      repeat (2) @(negedge clk);

      // reset during CAPTURE of a core load
      @(negedge clk);
      c_req_valid = 1; c_req_we = 0; c_req_addr = 64'h100;
      #1;
      check("rstmid_ready", 64'(c_req_ready), 1);
      @(negedge clk);
      c_req_valid = 0;
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
      last_port = 1;
      check("rstmid_mem_en", 64'(mem_en), 0);
      flag = c_resp_valid;
      for (int i = 0; i < 4; i++) begin @(negedge clk); flag |= c_resp_valid; end
      check("rstmid_no_resp", 64'(flag), 0);
      model(0, 64'h200, 0, m_err, m_rd, m_lat, m_idx);
      do_req("rstmid_dbg", 1, 0, 64'h200, 0, m_err, m_rd, m_lat, m_idx);
      check("rstmid_dbg_wait", 64'(waited), 0);

      // randomized traffic against the reference model
      for (int i = 0; i < 80; i++) begin
         bit p, we;
         p = 1'($urandom());
         we = 1'($urandom());
         a = {$urandom(), $urandom()};
         a[12:0] = 13'(($urandom_range(0, 1023) << 3) | (($urandom() % 5 == 0) ? $urandom_range(1, 7) : 0));
         v = {$urandom(), $urandom()};
         model(we, a, v, m_err, m_rd, m_lat, m_idx);
         do_req($sformatf("rnd%0d", i), p, we, a, v, m_err, m_rd, m_lat, m_idx);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
